// File: rtl/resultado_display.sv
// Output stage for the 4-bit calculator: latches result/flags/select on a rising
// edge of cargar and scans them onto a 4-digit active-low 7-segment display.
module resultado_display #(
   parameter int N           = 4,
   parameter int REFRESH_DIV = 50000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cargar,
   input  logic [N-1:0] salida_in,
   input  logic [3:0]   flags_in,
   input  logic [3:0]   seleccion_in,
   output logic         valido,
   output logic [3:0]   leds_flags,
   output logic [3:0]   an,
   output logic [6:0]   seg
);

   localparam int            PW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
   localparam logic [PW-1:0] PRESC_ONE = PW'(1);
   localparam bit            HAS_HI    = (N > 4);
   localparam logic [6:0]    SEG_DASH  = 7'b0111111;
   localparam logic [6:0]    SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      DIG0 = 2'd0,
      DIG1 = 2'd1,
      DIG2 = 2'd2,
      DIG3 = 2'd3
   } scan_t;

   function automatic logic [6:0] hex_seg(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'h0:    s = 7'b1000000;
         4'h1:    s = 7'b1111001;
         4'h2:    s = 7'b0100100;
         4'h3:    s = 7'b0110000;
         4'h4:    s = 7'b0011001;
         4'h5:    s = 7'b0010010;
         4'h6:    s = 7'b0000010;
         4'h7:    s = 7'b1111000;
         4'h8:    s = 7'b0000000;
         4'h9:    s = 7'b0010000;
         4'hA:    s = 7'b0001000;
         4'hB:    s = 7'b0000011;
         4'hC:    s = 7'b1000110;
         4'hD:    s = 7'b0100001;
         4'hE:    s = 7'b0000110;
         4'hF:    s = 7'b0001110;
         default: s = SEG_DASH;
      endcase
      return s;
   endfunction

   logic          cargar_prev_q, cargar_prev_d;
   logic [N-1:0]  result_q, result_d;
   logic [3:0]    flags_q, flags_d;
   logic [3:0]    sel_q, sel_d;
   logic          valido_q, valido_d;
   logic [PW-1:0] presc_q, presc_d;
   scan_t         scan_q, scan_d;
   logic [3:0]    an_q, an_d;
   logic [6:0]    seg_q, seg_d;
   logic [7:0]    res_ext_s;
   logic [6:0]    digit_s;

   // Next-state: capture on cargar rise, prescaler/scan advance, and display decode
   // evaluated on next-state values so the registered an/seg carry no extra latency.
   always_comb begin
      cargar_prev_d = cargar;
      result_d      = result_q;
      flags_d       = flags_q;
      sel_d         = sel_q;
      valido_d      = valido_q;
      presc_d       = presc_q;
      scan_d        = scan_q;
      an_d          = 4'b1110;
      digit_s       = SEG_BLANK;
      res_ext_s     = 8'h00;

      if (cargar && !cargar_prev_q) begin
         result_d = salida_in;
         flags_d  = flags_in;
         sel_d    = seleccion_in;
         valido_d = 1'b1;
      end else begin
         valido_d = valido_q;
      end

      if (presc_q == PRESC_MAX) begin
         presc_d = '0;
         case (scan_q)
            DIG0:    scan_d = DIG1;
            DIG1:    scan_d = DIG2;
            DIG2:    scan_d = DIG3;
            DIG3:    scan_d = DIG0;
            default: scan_d = DIG0;
         endcase
      end else begin
         presc_d = presc_q + PRESC_ONE;
      end

      res_ext_s[N-1:0] = result_d;
      case (scan_d)
         DIG0: begin
            an_d    = 4'b1110;
            digit_s = hex_seg(res_ext_s[3:0]);
         end
         DIG1: begin
            an_d    = 4'b1101;
            digit_s = HAS_HI ? hex_seg(res_ext_s[7:4]) : SEG_BLANK;
         end
         DIG2: begin
            an_d    = 4'b1011;
            digit_s = SEG_BLANK;
         end
         DIG3: begin
            an_d    = 4'b0111;
            digit_s = hex_seg(sel_d);
         end
         default: begin
            an_d    = 4'b1110;
            digit_s = SEG_DASH;
         end
      endcase

      if (valido_d) begin
         seg_d = digit_s;
      end else begin
         seg_d = SEG_DASH;
      end
   end

   // State registers with synchronous reset taking priority over capture.
   always_ff @(posedge clk) begin
      if (rst) begin
         cargar_prev_q <= 1'b0;
         result_q      <= '0;
         flags_q       <= 4'h0;
         sel_q         <= 4'h0;
         valido_q      <= 1'b0;
         presc_q       <= '0;
         scan_q        <= DIG0;
         an_q          <= 4'b1110;
         seg_q         <= SEG_DASH;
      end else begin
         cargar_prev_q <= cargar_prev_d;
         result_q      <= result_d;
         flags_q       <= flags_d;
         sel_q         <= sel_d;
         valido_q      <= valido_d;
         presc_q       <= presc_d;
         scan_q        <= scan_d;
         an_q          <= an_d;
         seg_q         <= seg_d;
      end
   end

   assign valido     = valido_q;
   assign leds_flags = flags_q;
   assign an         = an_q;
   assign seg        = seg_q;

endmodule
